initial_shift_processor: RTL and testbench



---
 rtl/initial_shift_processor_pkg.sv | 24 ++
 rtl/initial_shift_processor_if.sv | 30 +++
 rtl/initial_shift_processor_wrap_word_rotator.sv | 28 ++
 rtl/initial_shift_processor.sv | 86 ++++++++
 tb/tb_initial_shift_processor.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/initial_shift_processor_pkg.sv
// Shared constants and FSM state type for the initial shift processor.
// Polynomial geometry: 17669 bits stored in 553 words; the top word holds 5 bits.
// No logic; imported by the interface, the rotator and the top.
package initial_shift_processor_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int LAST_WORD_BITS = 5;
  localparam int N_BITS         = 17669;
  localparam int N_WORDS        = 553;
  localparam int K_WIDTH        = 5;
  localparam int TAIL_WIDTH     = WORD_WIDTH + LAST_WORD_BITS;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [TAIL_WIDTH-1:0] tail_t;
  typedef logic [K_WIDTH-1:0]    kidx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/initial_shift_processor_if.sv
// Request/result bundle between the shift datapath controller and the initial shift processor.
// master: drives start_process and operands, receives high_result/processing_done.
// slave : the processor side.
interface initial_shift_processor_if;
  import initial_shift_processor_pkg::*;

  logic         start_process;
  word_t        normal_word_zero;
  word_t        normal_word_551;
  word_t        normal_word_552;
  word_t        acc_word_high;
  logic [15:0]  high_shift;
  logic [9:0]   acc_start_idx_high;
  kidx_t        acc_shift_idx_high;
  word_t        high_result;
  logic         processing_done;

  modport master (
    output start_process, normal_word_zero, normal_word_551, normal_word_552,
           acc_word_high, high_shift, acc_start_idx_high, acc_shift_idx_high,
    input  high_result, processing_done
  );

  modport slave (
    input  start_process, normal_word_zero, normal_word_551, normal_word_552,
           acc_word_high, high_shift, acc_start_idx_high, acc_shift_idx_high,
    output high_result, processing_done
  );

endinterface

// File: rtl/initial_shift_processor_wrap_word_rotator.sv
// Combinational wrap-around word: rot = (tail >> (5+k)) | (word0 << (32-k)).
// Ports: word0 (poly bits 31..0), tail ({w552[4:0], w551}), k (0..31) -> rot.
// Zero latency; no flow control.
module wrap_word_rotator
  import initial_shift_processor_pkg::*;
(
  input  word_t word0,
  input  tail_t tail,
  input  kidx_t k,
  output word_t rot
);

  logic [5:0] tail_sh_amt;
  logic [5:0] w0_sh_amt;
  word_t      tail_part;
  word_t      w0_part;

  // Widen k before adding so that 5+31 = 36 does not wrap.
  assign tail_sh_amt = {1'b0, k} + 6'(LAST_WORD_BITS);
  assign w0_sh_amt   = 6'(WORD_WIDTH) - {1'b0, k};

  assign tail_part = word_t'(tail >> tail_sh_amt);
  // k = 0 means word 0 contributes nothing; avoid the 32-bit shift entirely.
  assign w0_part   = (k == '0) ? '0 : (word0 << w0_sh_amt);

  assign rot = tail_part | w0_part;

endmodule

// File: rtl/initial_shift_processor.sv
// Computes the wrap-around word of a cyclic rotation by x^shift and XORs it into an accumulator word.
// Ports: clk, rst (async, active-high), bus (slave: start/operands in, high_result/processing_done out).
// Latency: done pulses 3 cycles after the sampling edge; start is ignored while busy (no queuing).
module initial_shift_processor
  import initial_shift_processor_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  initial_shift_processor_if.slave    bus
);

  state_t state;
  state_t state_nxt;

  // Operand capture: later input changes must not affect an operation in flight.
  word_t                     word0_q;
  word_t                     word551_q;
  logic [LAST_WORD_BITS-1:0] word552_q;
  word_t                     acc_q;
  kidx_t                     k_q;
  tail_t                     tail_q;
  word_t                     result_q;
  word_t                     rot;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_process) state_nxt = LOAD;
      LOAD:    state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.processing_done = (state == DONE);
    bus.high_result     = result_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word0_q   <= '0;
      word551_q <= '0;
      word552_q <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      tail_q    <= '0;
      result_q  <= '0;
    end else begin
      if (state == IDLE && bus.start_process) begin
        word0_q   <= bus.normal_word_zero;
        word551_q <= bus.normal_word_551;
        word552_q <= bus.normal_word_552[LAST_WORD_BITS-1:0];
        acc_q     <= bus.acc_word_high;
        k_q       <= bus.acc_shift_idx_high;
      end
      if (state == LOAD) begin
        tail_q <= {word552_q, word551_q};
      end
      if (state == CALC) begin
        result_q <= rot ^ acc_q;
      end
    end
  end

  wrap_word_rotator u_rot (
    .word0 (word0_q),
    .tail  (tail_q),
    .k     (k_q),
    .rot   (rot)
  );

endmodule

// File: tb/tb_initial_shift_processor.sv
module tb_initial_shift_processor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  initial_shift_processor_if bus();

  initial_shift_processor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: view the tail as an integer and shift with wide arithmetic.
  function automatic logic [31:0] ref_result(input logic [31:0] w0, input logic [31:0] w551,
                                             input logic [31:0] w552, input logic [31:0] acc,
                                             input int k);
    logic [63:0] tail;
    logic [63:0] r;
    tail = {27'd0, w552[4:0], w551};
    r = tail >> (5 + k);
    if (k != 0) r = r | ({32'd0, w0} << (32 - k));
    return r[31:0] ^ acc;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_operands(input logic [31:0] w0, input logic [31:0] w551,
                                input logic [31:0] w552, input logic [31:0] acc, input int k);
    bus.normal_word_zero   = w0;
    bus.normal_word_551    = w551;
    bus.normal_word_552    = w552;
    bus.acc_word_high      = acc;
    bus.acc_shift_idx_high = 5'(k);
    bus.acc_start_idx_high = 10'd5;
    bus.high_shift         = 16'(5 * 32 - k);
  endtask

  // One operation: checks done latency, single pulse, and result. Inputs are
  // scrambled after capture; with poke=1 start is held high while busy.
  task automatic run_op(input string tag, input logic [31:0] w0, input logic [31:0] w551,
                        input logic [31:0] w552, input logic [31:0] acc, input int k,
                        input bit poke, output logic [31:0] res);
    int first_done;
    int pulses;
    @(negedge clk);
    drive_operands(w0, w551, w552, acc, k);
    bus.start_process = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_process = 1'b0;
    first_done = 0;
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        drive_operands($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 31));
        if (poke) bus.start_process = 1'b1;
      end
      if (c == 4) bus.start_process = 1'b0;
      if (bus.processing_done === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = c;
      end
    end
    check32({tag, "_latency"}, 32'(first_done), 32'd3);
    check32({tag, "_pulses"}, 32'(pulses), 32'd1);
    res = bus.high_result;
    check32({tag, "_result"}, res, ref_result(w0, w551, w552, acc, k));
  endtask

  logic [31:0] res;
  logic [31:0] res_zero552;
  int pulses_after_rst;

  initial begin
    bus.start_process = 1'b0;
    drive_operands(32'd0, 32'd0, 32'd0, 32'd0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check32("reset_result", bus.high_result, 32'h0);
    check32("reset_done", {31'd0, bus.processing_done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op("t1_k12", 32'hF601589C, 32'h126B25D1, 32'h15, 32'h0, 12, 1'b0, res);
    check32("t1_const", res, 32'h89CA8935);
    run_op("t2_accff", 32'hF601589C, 32'h126B25D1, 32'h15, 32'hFFFFFFFF, 12, 1'b0, res);
    check32("t2_const", res, 32'h763576CA);
    run_op("t3_k0", 32'hF601589C, 32'h126B25D1, 32'h15, 32'h0, 0, 1'b0, res);
    check32("t3_const", res, 32'hA893592E);
    run_op("t4_k31", 32'hF601589C, 32'h126B25D1, 32'h15, 32'h0, 31, 1'b0, res);
    check32("t4_const", res, 32'hEC02B139);

    // Upper bits of word 552 are masked: same as word 552 = 0.
    run_op("t5_w552_zero", 32'hF601589C, 32'h126B25D1, 32'h0, 32'h0, 12, 1'b0, res_zero552);
    check32("t5_zero_const", res_zero552, 32'h89C00935);
    run_op("t5_w552_mask", 32'hF601589C, 32'h126B25D1, 32'hFFFFFFE0, 32'h0, 12, 1'b0, res);
    check32("t5_mask_equal", res, res_zero552);

    // Start held high while busy must not launch a second operation.
    run_op("t6_busy_start", 32'h0BADF00D, 32'h12345678, 32'h1F, 32'hA5A5A5A5, 7, 1'b1, res);

    // Reset in CALC: outputs clear at once, no done pulse follows.
    @(negedge clk);
    drive_operands(32'hDEADBEEF, 32'hCAFEBABE, 32'h0A, 32'h0, 9);
    bus.start_process = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_process = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check32("rst_mid_result", bus.high_result, 32'h0);
    check32("rst_mid_done", {31'd0, bus.processing_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses_after_rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.processing_done === 1'b1) pulses_after_rst++;
    end
    check32("rst_mid_no_pulse", 32'(pulses_after_rst), 32'd0);
    check32("rst_mid_hold", bus.high_result, 32'h0);

    // Normal operation resumes after the abort.
    run_op("t7_after_rst", 32'hF601589C, 32'h126B25D1, 32'h15, 32'h0, 12, 1'b0, res);

    // Randomized operands against the reference.
    for (int i = 0; i < 20; i++) begin
      run_op("rand", $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 31), 1'(i % 3 == 0), res);
    end

    // Result holds while idle.
    repeat (3) @(negedge clk);
    check32("hold_idle", bus.high_result, res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
